// File: rtl/cla_seq_adder_if.sv
// Operand and result handshake bundle for the nibble-serial CLA adder.
// The master side supplies operands and accepts results; the slave side computes.
interface cla_seq_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_seq_adder.sv
// Wide adder that reuses one 4-bit carry-lookahead slice, one nibble per clock,
// least-significant nibble first, with valid/ready on both sides.
module cla_seq_adder #(
    parameter int NIBBLES = 4
) (
    input logic              clk,
    input logic              rst,
    cla_seq_adder_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    logic [W-1:0]   r_sum_sh;
    logic           r_carry;
    logic [IW-1:0]  r_idx;
    logic           r_cout;
    logic           r_ovf;

    logic [3:0]     w_g;
    logic [3:0]     w_p;
    logic [3:0]     w_c;
    logic           w_c4;
    logic [3:0]     w_nib;
    logic [W+3:0]   w_cat;
    logic [W-1:0]   w_sum_next;
    logic           w_last;

    assign w_g = r_a_sh[3:0] & r_b_sh[3:0];
    assign w_p = r_a_sh[3:0] ^ r_b_sh[3:0];

    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_c4   = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);

    assign w_nib = w_p ^ w_c;

    // New nibble enters at the top; works for any W including W==4.
    assign w_cat      = {w_nib, r_sum_sh};
    assign w_sum_next = w_cat[W+3:4];
    assign w_last     = (r_idx == IW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.a;
                        r_b_sh     <= bus.b;
                        r_carry    <= bus.cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= r_a_sh >> 4;
                    r_b_sh   <= r_b_sh >> 4;
                    r_carry  <= w_c4;
                    r_idx    <= r_idx + IW'(1);
                    if (w_last) begin
                        r_cout      <= w_c4;
                        r_ovf       <= (r_a_sh[3] ^ r_b_sh[3] ^ w_nib[3]) ^ w_c4;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum_sh;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule
